// File: rtl/cix_seq_if.sv
// Request/result handshake bundle for cix_seq.
// master = requester side, slave = the counter block.
interface cix_seq_if #(
    parameter int unsigned ORDER     = 3,
    parameter int unsigned LOG_PARTS = 2
);
    localparam int unsigned W    = 2 ** (ORDER + LOG_PARTS);
    localparam int unsigned CntW = ORDER + LOG_PARTS + 1;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CntW-1:0] out_count;
    logic            out_zero;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_count, out_zero
    );
endinterface

// File: rtl/cix_seq.sv
// Iterative wide-word CLZ / CTZ / popcount: streams a W-bit operand through a
// single C-bit count unit, one chunk per clock, and accumulates the result.
module cix_seq #(
    parameter int unsigned ORDER     = 3,
    parameter int unsigned LOG_PARTS = 2
) (
    input  logic       clock,
    input  logic       reset,
    cix_seq_if.slave   bus
);
    localparam int unsigned C      = 2 ** ORDER;
    localparam int unsigned P      = 2 ** LOG_PARTS;
    localparam int unsigned W      = C * P;
    localparam int unsigned CntW   = ORDER + LOG_PARTS + 1;
    localparam int unsigned ChCntW = ORDER + 1;
    localparam logic [LOG_PARTS-1:0] LastIdx = LOG_PARTS'(P - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [W-1:0]         data_q, data_d;
    logic [LOG_PARTS-1:0] idx_q, idx_d;
    logic [CntW-1:0]      acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [CntW-1:0]      out_count_q, out_count_d;
    logic                 out_zero_q, out_zero_d;

    logic [C-1:0]         chunk;
    logic                 chunk_zero;
    logic [ChCntW-1:0]    clz_cnt, ctz_cnt, pop_cnt, cix_cnt;
    logic [CntW-1:0]      acc_sum;
    logic                 finish;

    // Chunk select: mux on the latched operand indexed by the chunk counter.
    always_comb begin
        chunk = '0;
        for (int p = 0; p < P; p++) begin
            if (idx_q == LOG_PARTS'(p)) chunk = data_q[p*C +: C];
        end
    end

    // Shared chunk-width count unit; the latched op selects its mode.
    always_comb begin
        clz_cnt = ChCntW'(C);
        ctz_cnt = ChCntW'(C);
        pop_cnt = '0;
        // Ascending scan: last hit is the highest set bit.
        for (int i = 0; i < C; i++) begin
            if (chunk[i]) clz_cnt = ChCntW'(C - 1 - i);
            pop_cnt = pop_cnt + ChCntW'(chunk[i]);
        end
        // Descending scan: last hit is the lowest set bit.
        for (int i = C - 1; i >= 0; i--) begin
            if (chunk[i]) ctz_cnt = ChCntW'(i);
        end
        chunk_zero = (chunk == '0);
        if (op_q[1])      cix_cnt = pop_cnt;
        else if (op_q[0]) cix_cnt = ctz_cnt;
        else              cix_cnt = clz_cnt;
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its registered outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;
        acc_sum     = acc_q + CntW'(cix_cnt);
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    data_d  = bus.in_data;
                    acc_d   = '0;
                    idx_d   = (bus.in_op == 2'b00) ? LastIdx : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                if (op_q[1]) begin
                    finish = (idx_q == LastIdx);
                    idx_d  = idx_q + 1'b1;
                end else if (op_q[0]) begin
                    finish = !chunk_zero || (idx_q == LastIdx);
                    idx_d  = idx_q + 1'b1;
                end else begin
                    finish = !chunk_zero || (idx_q == '0);
                    idx_d  = idx_q - 1'b1;
                end
                if (finish) begin
                    out_count_d = acc_sum;
                    out_zero_d  = (data_q == '0);
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchronous reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_cix_seq.sv
// Scoreboard bench for cix_seq (ORDER=3, LOG_PARTS=2, W=32).
module tb_cix_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;

    cix_seq_if #(.ORDER(3), .LOG_PARTS(2)) bif ();

    cix_seq #(.ORDER(3), .LOG_PARTS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        int zero;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference: bit-level count plus chunk-walk latency.
    task automatic model(input logic [1:0] op, input logic [31:0] d,
                         output int cnt, output int zero, output int k);
        zero = (d == 32'h0) ? 1 : 0;
        k    = 1;
        cnt  = 32;
        if (op[1]) begin
            cnt = $countones(d);
            k   = 4;
        end else if (op == 2'b00) begin
            for (int i = 0; i < 32; i++) if (d[i]) cnt = 31 - i;
            for (int p = 3; p >= 1; p--) begin
                if (d[p*8 +: 8] != 8'h0) break;
                k++;
            end
        end else begin
            for (int i = 31; i >= 0; i--) if (d[i]) cnt = i;
            for (int p = 0; p <= 2; p++) begin
                if (d[p*8 +: 8] != 8'h0) break;
                k++;
            end
        end
    endtask

    // One full transaction: accept, latency check, optional backpressure, drain.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                          input int exp_cnt, input int exp_zero, input int exp_k,
                          input int hold);
        exp_t e;
        int   cyc;
        check({tag, "_in_ready"}, int'(bif.in_ready), 1);
        bif.in_valid = 1'b1;
        bif.in_op    = op;
        bif.in_data  = data;
        @(posedge clock);
        e.cnt  = exp_cnt;
        e.zero = exp_zero;
        sb.push_back(e);
        #1;
        // Garbage on the request side must be ignored outside IDLE.
        bif.in_valid = 1'($urandom);
        bif.in_op    = 2'($urandom);
        bif.in_data  = $urandom;
        cyc = 0;
        while (!bif.out_valid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_k);
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, int'(bif.out_valid), 1);
            check({tag, "_hold_ready"}, int'(bif.in_ready), 0);
            check({tag, "_hold_count"}, int'(bif.out_count), exp_cnt);
            bif.in_valid = ~bif.in_valid;
            bif.in_data  = $urandom;
            @(posedge clock);
            #1;
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        if (bif.out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_count"}, int'(bif.out_count), e.cnt);
            check({tag, "_zero"}, int'(bif.out_zero), e.zero);
        end
        @(posedge clock);
        #1;
        bif.out_ready = 1'b0;
        check({tag, "_drained"}, int'(bif.out_valid), 0);
        check({tag, "_ready_again"}, int'(bif.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, z, k;
        logic [1:0]  op;
        logic [31:0] d;
        bif.in_valid  = 1'b0;
        bif.in_op     = 2'b00;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_valid", int'(bif.out_valid), 0);
        check("rst_count", int'(bif.out_count), 0);
        check("rst_zero", int'(bif.out_zero), 0);
        check("rst_ready", int'(bif.in_ready), 1);

        run_op("clz_a", 2'b00, 32'h0001_0000, 15, 0, 2, 0);
        run_op("ctz_a", 2'b01, 32'h8000_0000, 31, 0, 4, 0);
        run_op("ctz_b", 2'b01, 32'h0000_0001, 0, 0, 1, 0);
        run_op("pcnt_a", 2'b10, 32'hF0F0_00FF, 16, 0, 4, 0);
        run_op("pcnt_r", 2'b11, 32'hF0F0_00FF, 16, 0, 4, 0);
        run_op("clz_0", 2'b00, 32'h0, 32, 1, 4, 0);
        run_op("ctz_0", 2'b01, 32'h0, 32, 1, 4, 0);
        run_op("pcnt_0", 2'b10, 32'h0, 0, 1, 4, 0);
        run_op("bp", 2'b00, 32'hFFFF_FFFF, 0, 0, 1, 5);
        run_op("after_bp", 2'b01, 32'h0000_0400, 10, 0, 2, 0);

        // Reset while RUN: no stale result may surface.
        bif.in_valid = 1'b1;
        bif.in_op    = 2'b10;
        bif.in_data  = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_valid", int'(bif.out_valid), 0);
        check("mid_rst_count", int'(bif.out_count), 0);
        check("mid_rst_zero", int'(bif.out_zero), 0);
        check("mid_rst_ready", int'(bif.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("mid_rst_no_stale", int'(bif.out_valid), 0);
        end
        run_op("clz_post_rst", 2'b00, 32'h0000_0100, 23, 0, 3, 0);

        // Randomised operands with some chunks forced to zero.
        for (int t = 0; t < 12; t++) begin
            op = 2'($urandom);
            d  = $urandom;
            for (int p = 0; p < 4; p++) if ($urandom_range(0, 1) == 0) d[p*8 +: 8] = 8'h0;
            model(op, d, c, z, k);
            run_op("rand", op, d, c, z, k, int'($urandom_range(0, 2)));
        end

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cix_seq.md
Name: cix_seq

Overview:
- Iterative wide-word bit counter: computes CLZ, CTZ or population count of a W-bit operand by streaming it through one chunk-width cix unit, one chunk per clock.
- Sits between a requester (ALU issue stage or bit-manipulation coprocessor) and the shared chunk counter.
- Avoids a full-width combinational counter at the cost of multi-cycle latency.
- valid/ready handshake on both sides.

Parameters:
- ORDER, 3: chunk width C = 2**ORDER bits; width of the internal cix instance.
- LOG_PARTS, 2: number of chunks P = 2**LOG_PARTS; operand width W = 2**(ORDER+LOG_PARTS).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  00 = CLZ, 01 = CTZ, 10 = PCNT, 11 = PCNT (reserved alias)
- in_data  in  W  operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_count  out  ORDER+LOG_PARTS+1  result count, range 0..W
- out_zero  out  1  operand was all zeros

Behaviour:
- Clock and reset:
  - One clock.
  - reset is synchronous and active-high.
  - On a reset edge: state = IDLE, out_valid = 0, out_count = 0, out_zero = 0, accumulator = 0, latched operand/op discarded.
  - Reset has priority over every other event, including mid-RUN and during DONE.
- States:
  - IDLE, RUN, DONE.
  - in_ready = (state == IDLE), decoded from registered state only; no combinational path from out_ready.
- IDLE:
  - On in_valid & in_ready at edge E0: latch in_data and in_op, clear accumulator, set chunk index, go to RUN.
  - Starting chunk index: P-1 (MSB chunk) for CLZ; 0 for CTZ and PCNT.
  - Without in_valid: stay in IDLE.
- RUN, one chunk per edge:
  - CLZ: chunk all-zero -> acc += C, index--; otherwise acc += clz(chunk), finish.
  - CTZ: chunk all-zero -> acc += C, index++; otherwise acc += ctz(chunk), finish.
  - PCNT: acc += popcount(chunk), index++.
  - Finish condition, CLZ/CTZ: first non-zero chunk, or last chunk processed.
  - Finish condition, PCNT: after chunk P-1.
  - On finish: out_count <= final acc, out_zero <= (operand == 0), out_valid <= 1, go to DONE.
- Latency:
  - k = number of RUN edges.
  - CLZ/CTZ: k = 1 + number of leading (CLZ) or trailing (CTZ) all-zero chunks, capped at P.
  - PCNT: k = P.
  - out_valid is high after edge E0+k.
- Zero operand:
  - CLZ = CTZ = W; PCNT = 0.
  - out_zero = 1 for every op.
- Arithmetic:
  - Accumulator is ORDER+LOG_PARTS+1 bits unsigned; cannot overflow (max W).
  - Chunk count from the cix instance is zero-extended.
- DONE:
  - out_valid, out_count, out_zero held stable while out_ready = 0.
  - in_valid ignored; in_ready = 0.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - out_count/out_zero keep their last values (don't-care while out_valid = 0).
  - Next accept is possible no earlier than the following edge; no same-cycle drain-and-accept.
- General:
  - Inputs other than out_ready are ignored outside IDLE.
  - The latched operand is unaffected by in_data changes during RUN/DONE.
  - Maximum throughput: one result per k+2 cycles.
- Structure:
  - Single shared chunk-width cix instance.
  - Chunk select is a mux on the latched operand indexed by the chunk counter.
  - Op select drives the cix mode.

Test Plan:
- ORDER=3, LOG_PARTS=2 (W=32); accept edge = E0 in all scenarios.
1. CLZ, in_data=32'h0001_0000 -> k=2; out_valid after E0+2; out_count=15, out_zero=0.
2. CTZ, in_data=32'h8000_0000 -> k=4; out_count=31, out_zero=0. Then CTZ, in_data=32'h0000_0001 -> k=1, out_count=0.
3. PCNT, in_data=32'hF0F0_00FF -> k=4; out_count=16. Op 11 with the same data -> out_count=16.
4. in_data=0 for CLZ, CTZ and PCNT -> out_count=32, 32 and 0 respectively; k=4 for each; out_zero=1.
5. Backpressure:
   - Stimulus: CLZ of 32'hFFFF_FFFF, hold out_ready=0 for 5 cycles, toggling in_valid and in_data throughout.
   - Required: out_valid=1, out_count=0, in_ready=0 held for all 5 cycles.
   - Raise out_ready: out_valid=0 next edge; in_ready=1 after that edge; the next request is accepted correctly.
6. Reset mid-operation:
   - Stimulus: PCNT accepted, assert reset at E0+2 for one cycle.
   - Required: after that edge out_valid=0, out_count=0, out_zero=0, in_ready=1; no stale result ever appears.
   - A new CLZ of 32'h0000_0100 then yields out_count=23.
